// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI main controller (spi_main_gen) and its
//   SCLK generator (spi_clk_gen).
//   Contents:
//     spi_state_e      frame state machine encoding (S_IDLE/S_SETUP/S_XFER/S_HOLD)
//     CPOL_IDLE_LOW    SCLK idle level after reset
//     CPHA_SAMPLE_LEAD cpha value that samples MISO on the leading SCLK edge
//     clog2()          constant-evaluable ceil(log2) used for derived widths
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } spi_state_e;

    localparam logic CPOL_IDLE_LOW    = 1'b0;
    localparam logic CPHA_SAMPLE_LEAD = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
//   SCLK divider for spi_main_gen. Counts CLK_DIV clk cycles per SCLK
//   half-period while enabled and toggles SCLK at each half-period boundary
//   when toggling is permitted.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     en         frame active (divider runs), divider held at 0 otherwise
//     toggle_en  the boundary ending this half-period produces an SCLK edge
//     load       preset SCLK to load_lvl (frame start)
//     load_lvl   SCLK level loaded on load (new CPOL)
//     idle_lvl   latched CPOL, distinguishes leading from trailing edges
//     sclk       serial clock output (registered)
//     tick       last clk cycle of the current half-period
//     lead_stb   tick that moves SCLK away from its idle level
//     trail_stb  tick that returns SCLK to its idle level
// -----------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    input  logic load,
    input  logic load_lvl,
    input  logic idle_lvl,
    output logic sclk,
    output logic tick,
    output logic lead_stb,
    output logic trail_stb
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;

    always_comb begin
        tick      = en && (div_q == DIV_LAST);
        lead_stb  = tick && toggle_en && (sclk_q == idle_lvl);
        trail_stb = tick && toggle_en && (sclk_q != idle_lvl);

        div_d = div_q;
        if (!en || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // SCLK keeps its last level between frames so it idles at CPOL.
        sclk_d = sclk_q;
        if (load) begin
            sclk_d = load_lvl;
        end else if (tick && toggle_en) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_main_gen.sv
// -----------------------------------------------------------------------------
// spi_main_gen
//   Parametrised SPI main controller. One full-duplex frame of DATA_W bits per
//   accepted start, runtime CPOL/CPHA, NUM_CS active-low chip selects, SCLK
//   half-period of CLK_DIV clk cycles. Frame: IDLE -> SETUP -> XFER -> HOLD.
//   Optional feature macro: SPI_MAIN_LSB_FIRST_EN adds the lsb_first input
//   (latched with start) selecting LSB-first shifting; without it the frame is
//   always MSB first.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     start      frame request, accepted only when idle and not busy
//     cs_sel     target chip-select index (out of range selects nothing)
//     cpol,cpha  SPI mode, latched with start
//     tx         word to send, latched with start
//     rx         last received word, updated in the done cycle
//     busy       frame in progress (cycle after acceptance through done)
//     done       one-cycle completion pulse
//     cs_n       active-low chip selects
//     sclk,mosi  serial clock and data out
//     miso       serial data in
//     lsb_first  (SPI_MAIN_LSB_FIRST_EN only) LSB-first frame when 1
// -----------------------------------------------------------------------------
module spi_main_gen
    import spi_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int NUM_CS   = 1,
    parameter int CLK_DIV  = 1,
    parameter int CS_SEL_W = (NUM_CS > 1) ? clog2(NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DATA_W-1:0]   tx,
    output logic [DATA_W-1:0]   rx,
    output logic                busy,
    output logic                done,
    output logic [NUM_CS-1:0]   cs_n,
    output logic                sclk,
    output logic                mosi,
`ifdef SPI_MAIN_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    input  logic                miso
);

    localparam int              HC_W          = clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] HC_LAST       = HC_W'(2 * DATA_W - 1);
    localparam logic [HC_W-1:0] HC_LAST_TRAIL = HC_W'(2 * DATA_W - 2);

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                   input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    spi_state_e        state_q, state_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mosi_q, mosi_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d, cs_dec;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;

    logic lsb_sel;   // bit order of the frame in flight
    logic lsb_in;    // bit order requested with start
    logic accept, clk_en, toggle_en;
    logic tick, lead_stb, trail_stb, put_stb, smp_stb;

`ifdef SPI_MAIN_LSB_FIRST_EN
    logic lsb_q, lsb_d;

    always_comb begin
        lsb_d = lsb_q;
        if (accept) begin
            lsb_d = lsb_first;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsb_q <= 1'b0;
        end else begin
            lsb_q <= lsb_d;
        end
    end

    assign lsb_sel = lsb_q;
    assign lsb_in  = lsb_first;
`else
    assign lsb_sel = 1'b0;
    assign lsb_in  = 1'b0;
`endif

    // The done cycle is already IDLE but still busy, so a start there is ignored.
    assign accept    = (state_q == S_IDLE) && !busy_q && start;
    assign clk_en    = (state_q != S_IDLE);
    // No SCLK edge at the end of the last half-period: the line is back at CPOL.
    assign toggle_en = (state_q == S_SETUP) || ((state_q == S_XFER) && (hcnt_q != HC_LAST));

    // cpha=0 drives on trailing edges, except the final one so MOSI keeps the
    // last bit; cpha=1 drives on leading edges. Sampling uses the other edge.
    assign put_stb = (cpha_q == CPHA_SAMPLE_LEAD) ? (trail_stb && (hcnt_q != HC_LAST_TRAIL))
                                                  : lead_stb;
    assign smp_stb = (cpha_q == CPHA_SAMPLE_LEAD) ? lead_stb : trail_stb;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (clk_en),
        .toggle_en (toggle_en),
        .load      (accept),
        .load_lvl  (cpol),
        .idle_lvl  (cpol_q),
        .sclk      (sclk),
        .tick      (tick),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    // Out-of-range indices match no line, leaving every select high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mosi_d  = mosi_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        cs_n_d  = cs_n_q;
        rx_d    = rx_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;

        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    cs_n_d  = cs_dec;
                    // cpha=0 presents the first bit during SETUP, before any edge.
                    if (cpha == CPHA_SAMPLE_LEAD) begin
                        mosi_d  = first_bit(tx, lsb_in);
                        tx_sr_d = shift_tx(tx, lsb_in);
                    end else begin
                        tx_sr_d = tx;
                    end
                end
            end
            S_SETUP: begin
                if (tick) begin
                    state_d = S_XFER;
                    hcnt_d  = '0;
                end
            end
            S_XFER: begin
                if (tick) begin
                    if (hcnt_q == HC_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        hcnt_d = hcnt_q + HC_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    cs_n_d  = '1;
                    rx_d    = rx_sr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (put_stb) begin
            mosi_d  = first_bit(tx_sr_q, lsb_sel);
            tx_sr_d = shift_tx(tx_sr_q, lsb_sel);
        end
        if (smp_stb) begin
            rx_sr_d = shift_rx(rx_sr_q, miso, lsb_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cpol_q  <= CPOL_IDLE_LOW;
            cpha_q  <= CPHA_SAMPLE_LEAD;
            cs_n_q  <= '1;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mosi_q  <= mosi_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            cs_n_q  <= cs_n_d;
            rx_q    <= rx_d;
        end
    end

    // Shift registers are fully rewritten by every frame, so they need no reset.
    always_ff @(posedge clk) begin
        tx_sr_q <= tx_sr_d;
        rx_sr_q <= rx_sr_d;
    end

    assign rx   = rx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign cs_n = cs_n_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_main_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_main_gen
//   Directed bench for spi_main_gen. Instance A: DATA_W=128, NUM_CS=1,
//   CLK_DIV=1, MISO from loopback or a behavioural SPI sub. Instance B:
//   DATA_W=8, NUM_CS=4, CLK_DIV=3, loopback. Cycle 0 is the cycle in which
//   start is high; outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spi_main_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A
    logic         start_a, cs_sel_a, cpol_a, cpha_a;
    logic         busy_a, done_a, sclk_a, mosi_a, miso_a, loop_a;
    logic [0:0]   cs_n_a;
    logic [127:0] tx_a, rx_a;

    // Instance B
    logic         start_b, cpol_b, cpha_b, busy_b, done_b, sclk_b, mosi_b;
    logic [1:0]   cs_sel_b;
    logic [3:0]   cs_n_b;
    logic [7:0]   tx_b, rx_b;

`ifdef SPI_MAIN_LSB_FIRST_EN
    logic lsb_a, lsb_b;
`endif

    // Behavioural SPI sub attached to instance A
    logic [127:0] sub_tx, sub_sr, sub_rx;
    logic         sub_miso, sub_cpol, sub_cpha, prev_sclk, prev_cs, sub_lead;

    assign miso_a = loop_a ? mosi_a : sub_miso;

    spi_main_gen #(.DATA_W(128), .NUM_CS(1), .CLK_DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cs_sel(cs_sel_a), .cpol(cpol_a), .cpha(cpha_a),
        .tx(tx_a), .rx(rx_a), .busy(busy_a), .done(done_a), .cs_n(cs_n_a), .sclk(sclk_a),
        .mosi(mosi_a),
`ifdef SPI_MAIN_LSB_FIRST_EN
        .lsb_first(lsb_a),
`endif
        .miso(miso_a)
    );

    spi_main_gen #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cs_sel(cs_sel_b), .cpol(cpol_b), .cpha(cpha_b),
        .tx(tx_b), .rx(rx_b), .busy(busy_b), .done(done_b), .cs_n(cs_n_b), .sclk(sclk_b),
        .mosi(mosi_b),
`ifdef SPI_MAIN_LSB_FIRST_EN
        .lsb_first(lsb_b),
`endif
        .miso(mosi_b)
    );

    // Sub reacts to SCLK edges seen on the falling clk edge, well away from
    // the rising edge on which the main samples MISO.
    always @(negedge clk) begin
        if (prev_cs && !cs_n_a[0]) begin
            sub_sr = sub_tx;
            sub_rx = '0;
            if (!sub_cpha) begin
                sub_miso = sub_tx[127];
                sub_sr   = sub_tx << 1;
            end
        end else if (!cs_n_a[0] && (sclk_a != prev_sclk)) begin
            sub_lead = (sclk_a != sub_cpol);
            if (sub_lead ^ sub_cpha) begin
                sub_rx = {sub_rx[126:0], mosi_a};
            end else begin
                sub_miso = sub_sr[127];
                sub_sr   = sub_sr << 1;
            end
        end
        prev_cs   = cs_n_a[0];
        prev_sclk = sclk_a;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-frame observations on instance A
    int   a_busy_low, a_cs_low, a_toggles, a_mosi_hi;
    logic a_sclk_c1;

    task automatic go_a(input logic [127:0] t, input logic pol, input logic pha, input logic sel);
        @(negedge clk);
        tx_a = t; cpol_a = pol; cpha_a = pha; cs_sel_a = sel; start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        // Mid-frame input changes must not disturb the frame in flight.
        tx_a = ~t; cpol_a = ~pol; cpha_a = ~pha; cs_sel_a = ~sel;
    endtask

    task automatic wait_done_a(input int limit, output int cyc);
        logic prev;
        cyc = -1; a_busy_low = 0; a_cs_low = 0; a_toggles = 0; a_mosi_hi = 0;
        prev = sclk_a;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (n == 1) a_sclk_c1 = sclk_a;
            else if (sclk_a !== prev) a_toggles++;
            prev = sclk_a;
            if (busy_a !== 1'b1) a_busy_low++;
            if (done_a === 1'b1) begin
                cyc = n;
                break;
            end
            if (cs_n_a === 1'b0) a_cs_low++;
            if (mosi_a === 1'b1) a_mosi_hi++;
        end
    endtask

    // Per-frame observations on instance B
    int b_cs_bad, b_tog1, b_tog2, b_ntog;

    task automatic go_b(input logic [7:0] t, input logic pol, input logic pha, input logic [1:0] sel);
        @(negedge clk);
        tx_b = t; cpol_b = pol; cpha_b = pha; cs_sel_b = sel; start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        tx_b = ~t; cpol_b = ~pol; cpha_b = ~pha; cs_sel_b = ~sel;
    endtask

    task automatic wait_done_b(input int limit, input logic [3:0] cs_exp, output int cyc);
        logic prev;
        cyc = -1; b_cs_bad = 0; b_tog1 = -1; b_tog2 = -1; b_ntog = 0;
        prev = sclk_b;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if ((n > 1) && (sclk_b !== prev)) begin
                b_ntog++;
                if (b_tog1 < 0) b_tog1 = n;
                else if (b_tog2 < 0) b_tog2 = n;
            end
            prev = sclk_b;
            if (done_b === 1'b1) begin
                cyc = n;
                break;
            end
            if (cs_n_b !== cs_exp) b_cs_bad++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   cnt;
        logic pol, pha;

        rst = 1'b1;
        start_a = 1'b0; cs_sel_a = 1'b0; cpol_a = 1'b0; cpha_a = 1'b0; tx_a = '0; loop_a = 1'b1;
        start_b = 1'b0; cs_sel_b = 2'd0; cpol_b = 1'b0; cpha_b = 1'b0; tx_b = '0;
        sub_tx = 128'hfa4d; sub_sr = '0; sub_rx = '0; sub_miso = 1'b0;
        sub_cpol = 1'b0; sub_cpha = 1'b0; prev_sclk = 1'b0; prev_cs = 1'b1; sub_lead = 1'b0;
`ifdef SPI_MAIN_LSB_FIRST_EN
        lsb_a = 1'b0; lsb_b = 1'b0;
`endif

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs_n_a", 128'(cs_n_a), 128'(1));
        check_eq("rst_sclk_a", 128'(sclk_a), 128'(0));
        check_eq("rst_mosi_a", 128'(mosi_a), 128'(0));
        check_eq("rst_rx_a",   rx_a,         128'(0));
        check_eq("rst_busy_a", 128'(busy_a), 128'(0));
        check_eq("rst_done_a", 128'(done_a), 128'(0));
        check_eq("rst_cs_n_b", 128'(cs_n_b), 128'(4'hf));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Mode 0 loopback, full 128-bit frame
        go_a(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b0);
        wait_done_a(400, cyc);
        check_eq("m0_done_cycle", 128'(cyc), 128'(259));
        check_eq("m0_rx", rx_a, 128'h00112233445566778899aabbccddeeff);
        check_eq("m0_busy_gaps", 128'(a_busy_low), 128'(0));
        check_eq("m0_cs_low_cycles", 128'(a_cs_low), 128'(258));
        check_eq("m0_sclk_toggles", 128'(a_toggles), 128'(256));
        check_eq("m0_sclk_setup", 128'(a_sclk_c1), 128'(0));
        check_eq("m0_cs_n_done", 128'(cs_n_a), 128'(1));
        @(negedge clk);
        check_eq("m0_busy_after", 128'(busy_a), 128'(0));
        check_eq("m0_done_after", 128'(done_a), 128'(0));

        // Modes 1..3 against the sub model
        loop_a = 1'b0;
        for (int m = 1; m < 4; m++) begin
            pol = (m >= 2);
            pha = (m % 2 == 1);
            sub_cpol = pol;
            sub_cpha = pha;
            go_a(128'habde1, pol, pha, 1'b0);
            wait_done_a(400, cyc);
            check_eq($sformatf("m%0d_done_cycle", m), 128'(cyc), 128'(259));
            check_eq($sformatf("m%0d_rx", m), rx_a, 128'hfa4d);
            check_eq($sformatf("m%0d_sub_rx", m), sub_rx, 128'habde1);
            check_eq($sformatf("m%0d_sclk_setup", m), 128'(a_sclk_c1), 128'(pol));
            check_eq($sformatf("m%0d_sclk_idle", m), 128'(sclk_a), 128'(pol));
            check_eq($sformatf("m%0d_sclk_toggles", m), 128'(a_toggles), 128'(256));
        end
        loop_a = 1'b1;

        // Out-of-range chip select: frame runs, no select asserted
        go_a(128'hdeadbeef_0123_4567_89ab_cdef_f00d_cafe, 1'b0, 1'b0, 1'b1);
        wait_done_a(400, cyc);
        check_eq("oor_done_cycle", 128'(cyc), 128'(259));
        check_eq("oor_cs_low_cycles", 128'(a_cs_low), 128'(0));
        check_eq("oor_rx", rx_a, 128'hdeadbeef_0123_4567_89ab_cdef_f00d_cafe);

        // Start pulses while busy are ignored
        go_a(128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
        fork
            wait_done_a(400, cyc);
            begin
                repeat (40) @(posedge clk);
                #1;
                start_a = 1'b1; tx_a = 128'h5555;
                @(posedge clk);
                #1;
                start_a = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                start_a = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                start_a = 1'b0;
            end
        join
        check_eq("busy_start_done_cycle", 128'(cyc), 128'(259));
        check_eq("busy_start_rx", rx_a, 128'h8000_0000_0000_0000_0000_0000_0000_0001);

        // Start held through the done cycle: accepted only in the cycle after
        tx_a = 128'h0f0f_1234; cpol_a = 1'b0; cpha_a = 1'b0; cs_sel_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        tx_a = '1;
        wait_done_a(400, cyc);
        check_eq("b2b_done_cycle", 128'(cyc), 128'(259));
        check_eq("b2b_rx", rx_a, 128'h0f0f_1234);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) cnt++;
        end
        check_eq("b2b_no_extra_frame", 128'(cnt), 128'(0));

        // Reset in mid-XFER (cycle 100)
        go_a(128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe, 1'b1, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_cs_n", 128'(cs_n_a), 128'(1));
        check_eq("midrst_sclk", 128'(sclk_a), 128'(0));
        check_eq("midrst_mosi", 128'(mosi_a), 128'(0));
        check_eq("midrst_busy", 128'(busy_a), 128'(0));
        check_eq("midrst_rx",   rx_a,         128'(0));
        cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) cnt++;
        end
        check_eq("midrst_no_done", 128'(cnt), 128'(0));

        // Start and reset together: reset wins
        @(negedge clk);
        start_a = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0; rst = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || cs_n_a !== 1'b1) cnt++;
        end
        check_eq("start_rst_idle", 128'(cnt), 128'(0));

        // Instance B: cs_sel=2, mode 0, half-period 3 cycles
        go_b(8'ha5, 1'b0, 1'b0, 2'd2);
        wait_done_b(100, 4'b1011, cyc);
        check_eq("b_sel2_done_cycle", 128'(cyc), 128'(55));
        check_eq("b_sel2_rx", 128'(rx_b), 128'(8'ha5));
        check_eq("b_sel2_cs_bad", 128'(b_cs_bad), 128'(0));
        check_eq("b_sel2_first_edge", 128'(b_tog1), 128'(4));
        check_eq("b_sel2_second_edge", 128'(b_tog2), 128'(7));
        check_eq("b_sel2_toggles", 128'(b_ntog), 128'(16));
        check_eq("b_sel2_cs_n_done", 128'(cs_n_b), 128'(4'hf));

        // Instance B: cs_sel=3, mode 3
        go_b(8'h3c, 1'b1, 1'b1, 2'd3);
        wait_done_b(100, 4'b0111, cyc);
        check_eq("b_sel3_done_cycle", 128'(cyc), 128'(55));
        check_eq("b_sel3_rx", 128'(rx_b), 128'(8'h3c));
        check_eq("b_sel3_cs_bad", 128'(b_cs_bad), 128'(0));
        check_eq("b_sel3_first_edge", 128'(b_tog1), 128'(4));
        check_eq("b_sel3_sclk_idle", 128'(sclk_b), 128'(1));

`ifdef SPI_MAIN_LSB_FIRST_EN
        // LSB first: only the first bit period drives MOSI high
        lsb_a = 1'b1;
        go_a(128'h1, 1'b0, 1'b0, 1'b0);
        wait_done_a(400, cyc);
        check_eq("lsb_done_cycle", 128'(cyc), 128'(259));
        check_eq("lsb_mosi_hi_cycles", 128'(a_mosi_hi), 128'(2));
        check_eq("lsb_rx", rx_a, 128'h1);
        lsb_a = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
